// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 WIDTH-bit mux among four requesters,
// with a valid/ready output handshake and a per-tenure transfer cap.
module rr_mux_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic             out_ready,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state_reg, state_next;
    logic [3:0] gnt_reg, gnt_next;
    logic [1:0] sel_reg, sel_next;
    logic [1:0] last_reg, last_next;
    logic [3:0] hold_reg, hold_next;

    logic [WIDTH-1:0] d_arr [4];
    logic [3:0]       rot_req;
    logic [1:0]       offset;
    logic [1:0]       winner;
    logic             transfer;

    assign d_arr[0] = d0;
    assign d_arr[1] = d1;
    assign d_arr[2] = d2;
    assign d_arr[3] = d3;

    // rot_req[k] is the request of the requester k+1 places after the last winner.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_req[gi] = req[last_reg + 2'(gi + 1)];
        end
    endgenerate

    always_comb begin
        offset = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot_req[k]) begin
                offset = 2'(k);
            end
        end
    end

    assign winner   = last_reg + 2'd1 + offset;
    assign y        = d_arr[sel_reg];
    assign busy     = (state_reg == GRANT);
    assign y_valid  = busy && req[sel_reg];
    assign transfer = y_valid && out_ready;
    assign gnt      = gnt_reg;
    assign sel      = sel_reg;

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        sel_next   = sel_reg;
        last_next  = last_reg;
        hold_next  = hold_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next = GRANT;
                    gnt_next   = 4'b0001 << winner;
                    sel_next   = winner;
                    last_next  = winner;
                    hold_next  = 4'd0;
                end
            end
            GRANT: begin
                // Release leaves sel untouched; only the grant and count clear.
                if (!req[sel_reg] || (transfer && hold_reg == HOLD_LAST)) begin
                    state_next = IDLE;
                    gnt_next   = 4'b0000;
                    hold_next  = 4'd0;
                end else if (transfer) begin
                    hold_next = hold_reg + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = 4'b0000;
                hold_next  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            gnt_reg   <= 4'b0000;
            sel_reg   <= 2'd0;
            last_reg  <= 2'd3;
            hold_reg  <= 4'd0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            sel_reg   <= sel_next;
            last_reg  <= last_next;
            hold_reg  <= hold_next;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: one instance with MAX_HOLD=4 (a_*) and one with MAX_HOLD=1 (b_*).
module tb_rr_mux_arbiter;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   req = 4'b0000;
    logic [W-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic         out_ready = 1'b0;

    logic [3:0]   a_gnt, b_gnt;
    logic [1:0]   a_sel, b_sel;
    logic [W-1:0] a_y, b_y;
    logic         a_yv, b_yv, a_busy, b_busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: index 0 mirrors the MAX_HOLD=4 instance, index 1 the MAX_HOLD=1 one.
    int m_busy [2];
    int m_sel  [2];
    int m_last [2];
    int m_cnt  [2];
    int m_max  [2] = '{4, 1};

    typedef struct {
        logic [3:0]   req;
        logic         rdy;
        logic [3:0]   gnt;
        logic [1:0]   sel;
        logic         yv;
        logic [W-1:0] y;
    } vec_t;
    vec_t tbl [10];

    rr_mux_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .req(req),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .out_ready(out_ready),
        .gnt(a_gnt), .sel(a_sel), .y(a_y), .y_valid(a_yv), .busy(a_busy)
    );

    rr_mux_arbiter #(.WIDTH(W), .MAX_HOLD(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .req(req),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .out_ready(out_ready),
        .gnt(b_gnt), .sel(b_sel), .y(b_y), .y_valid(b_yv), .busy(b_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dsel(input int s);
        case (s)
            0: return int'(d0);
            1: return int'(d1);
            2: return int'(d2);
            default: return int'(d3);
        endcase
    endfunction

    function automatic int exp_gnt(input int i);
        return (m_busy[i] != 0) ? (1 << m_sel[i]) : 0;
    endfunction

    function automatic int exp_yv(input int i);
        return ((m_busy[i] != 0) && req[m_sel[i]]) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0;
            m_sel[i]  = 0;
            m_last[i] = 3;
            m_cnt[i]  = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (m_busy[i] == 0) begin
                if (req != 4'b0000) begin
                    for (int k = 1; k <= 4; k++) begin
                        int w;
                        w = (m_last[i] + k) % 4;
                        if (req[w] && m_busy[i] == 0) begin
                            m_busy[i] = 1;
                            m_sel[i]  = w;
                            m_last[i] = w;
                            m_cnt[i]  = 0;
                        end
                    end
                end
            end else if (!req[m_sel[i]]) begin
                m_busy[i] = 0;
            end else if (out_ready) begin
                $display("xfer inst%0d sel=%0d y=%h", i, m_sel[i], dsel(m_sel[i]));
                m_cnt[i]++;
                if (m_cnt[i] == m_max[i]) m_busy[i] = 0;
            end
        end
    endtask

    task automatic check_model();
        chk("a_gnt",  int'(a_gnt),  exp_gnt(0));
        chk("a_sel",  int'(a_sel),  m_sel[0]);
        chk("a_y",    int'(a_y),    dsel(m_sel[0]));
        chk("a_yv",   int'(a_yv),   exp_yv(0));
        chk("a_busy", int'(a_busy), m_busy[0]);
        chk("b_gnt",  int'(b_gnt),  exp_gnt(1));
        chk("b_sel",  int'(b_sel),  m_sel[1]);
        chk("b_y",    int'(b_y),    dsel(m_sel[1]));
        chk("b_yv",   int'(b_yv),   exp_yv(1));
        chk("b_busy", int'(b_busy), m_busy[1]);
    endtask

    task automatic settle();
        #1;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Assert reset away from the edge, check reset values, release after the next edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_a_gnt", int'(a_gnt), 0);
        chk("rst_a_yv",  int'(a_yv),  0);
        chk("rst_b_gnt", int'(b_gnt), 0);
        chk("rst_b_busy", int'(b_busy), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 4'h0};
        tbl[1] = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 4'h0};
        tbl[2] = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 4'h0};
        tbl[3] = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 4'h5};
        tbl[4] = '{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 4'h5};
        tbl[5] = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 4'hA};
        tbl[6] = '{4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 4'hA};
        tbl[7] = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 4'hF};
        tbl[8] = '{4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 4'hF};
        tbl[9] = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 4'h0};

        d0 = 4'h0; d1 = 4'h5; d2 = 4'hA; d3 = 4'hF;

        // Rotation with MAX_HOLD=1, table driven.
        req = 4'b1111; out_ready = 1'b1;
        do_reset();
        for (int v = 0; v < 10; v++) begin
            req = tbl[v].req;
            out_ready = tbl[v].rdy;
            settle();
            chk("tbl_gnt", int'(b_gnt), int'(tbl[v].gnt));
            chk("tbl_sel", int'(b_sel), int'(tbl[v].sel));
            chk("tbl_yv",  int'(b_yv),  int'(tbl[v].yv));
            chk("tbl_y",   int'(b_y),   int'(tbl[v].y));
            $display("vec %0d gnt=%b sel=%0d yv=%0d y=%h", v, b_gnt, b_sel, b_yv, b_y);
            tick();
        end

        // Hold cap with MAX_HOLD=4: four words from 0, bubble, four words from 1.
        req = 4'b0011; out_ready = 1'b1;
        do_reset();
        begin
            int exp_a [11] = '{0, 1, 1, 1, 1, 0, 2, 2, 2, 2, 0};
            for (int c = 0; c < 11; c++) begin
                settle();
                chk("cap_gnt", int'(a_gnt), exp_a[c]);
                if (exp_a[c] != 0) chk("cap_y", int'(a_y), (exp_a[c] == 1) ? 0 : 5);
                tick();
            end
        end

        // Backpressure on requester 2, then resume for exactly four transfers.
        req = 4'b0100; out_ready = 1'b0;
        do_reset();
        settle();
        tick();
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("bp_gnt", int'(a_gnt), 4);
            chk("bp_yv",  int'(a_yv),  1);
            chk("bp_y",   int'(a_y),   10);
            tick();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("bp_res_gnt", int'(a_gnt), 4);
            tick();
        end
        settle();
        chk("bp_rel_gnt", int'(a_gnt), 0);
        tick();

        // Early drop by requester 3 after two transfers; requester 0 wins next.
        req = 4'b1000; out_ready = 1'b1;
        do_reset();
        settle();
        tick();
        for (int c = 0; c < 2; c++) begin
            settle();
            chk("drop_gnt", int'(a_gnt), 8);
            tick();
        end
        req = 4'b0001;
        settle();
        chk("drop_yv",   int'(a_yv),  0);
        chk("drop_gnt3", int'(a_gnt), 8);
        tick();
        settle();
        chk("drop_rel",  int'(a_gnt), 0);
        tick();
        settle();
        chk("drop_next", int'(a_gnt), 1);
        tick();

        // Asynchronous reset in the middle of a tenure.
        req = 4'b0010; out_ready = 1'b0;
        do_reset();
        tick();
        settle();
        chk("ar_pre_gnt", int'(b_gnt), 2);
        reset_n = 1'b0;
        #1;
        chk("ar_gnt",  int'(b_gnt),  0);
        chk("ar_busy", int'(b_busy), 0);
        chk("ar_gnt4", int'(a_gnt),  0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Randomized stimulus against the reference model.
        for (int c = 0; c < 400; c++) begin
            req = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                d0 = 4'($urandom); d1 = 4'($urandom);
                d2 = 4'($urandom); d3 = 4'($urandom);
            end
            settle();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
